// File: rtl/color_mapping_norm_pipe.sv
// Purpose: floor-subtract, Q2.16 scale and saturate power samples to a palette index; per-frame min/max stats.
// Latency: 3 cycles from accepted input to out_tvalid, 1 beat/cycle throughput.
// Backpressure: whole pipe stalls when out_tvalid=1 and out_tready=0; in_tready = !out_tvalid | out_tready.
//
// Ports:
//   ap_clk, ap_rst           clock, synchronous active-high reset
//   cfg_min, cfg_scale       floor and Q2.16 gain, captured on each accepted SOF beat
//   in_t*                    AXI-Stream input: tdata sample, tuser SOF, tlast EOF
//   out_t*                   AXI-Stream output: tdata palette index, tuser/tlast delayed with data
//   stat_min, stat_max       min/max of the last completed frame
//   stat_valid               1-cycle pulse when stat_min/stat_max update
module color_mapping_norm_pipe #(
    parameter int DATA_W = 18,
    parameter int SHIFT  = 16,
    parameter int IDX_W  = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [DATA_W-1:0] cfg_min,
    input  logic [DATA_W-1:0] cfg_scale,
    input  logic [DATA_W-1:0] in_tdata,
    input  logic              in_tuser,
    input  logic              in_tlast,
    input  logic              in_tvalid,
    output logic              in_tready,
    output logic [IDX_W-1:0]  out_tdata,
    output logic              out_tuser,
    output logic              out_tlast,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic [DATA_W-1:0] stat_min,
    output logic [DATA_W-1:0] stat_max,
    output logic              stat_valid
);

    localparam int P_W = 2 * DATA_W;
    localparam logic [P_W-1:0] IDX_MAX = P_W'((64'd1 << IDX_W) - 64'd1);

    logic en;
    logic accept;

    // Coefficients latched from the most recent SOF beat
    logic [DATA_W-1:0] min_l;
    logic [DATA_W-1:0] scale_l;

    // Running statistics of the frame in progress
    logic [DATA_W-1:0] run_min;
    logic [DATA_W-1:0] run_max;

    // Stage 1: floor-subtracted sample and the gain chosen for it
    logic              s1_vld;
    logic [DATA_W-1:0] s1_d;
    logic [DATA_W-1:0] s1_scale;
    logic              s1_user;
    logic              s1_last;

    // Stage 2: full-width product
    logic              s2_vld;
    logic [P_W-1:0]    s2_p;
    logic              s2_user;
    logic              s2_last;

    logic [DATA_W-1:0] sel_min;
    logic [DATA_W-1:0] sel_scale;
    logic [DATA_W-1:0] diff;
    logic [P_W-1:0]    prod;
    logic [P_W-1:0]    q_full;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] nxt_min;
    logic [DATA_W-1:0] nxt_max;

    assign en        = !out_tvalid || out_tready;
    assign in_tready = en;
    assign accept    = in_tvalid && en;

    // An SOF beat uses the fresh config directly so the first pixel already sees the new frame's coefficients
    assign sel_min   = in_tuser ? cfg_min   : min_l;
    assign sel_scale = in_tuser ? cfg_scale : scale_l;
    assign diff      = (in_tdata > sel_min) ? (in_tdata - sel_min) : '0;

    assign prod   = {{DATA_W{1'b0}}, s1_d} * {{DATA_W{1'b0}}, s1_scale};
    // Saturate against the whole shifted product so large gains never wrap
    assign q_full = s2_p >> SHIFT;
    assign idx    = (q_full > IDX_MAX) ? {IDX_W{1'b1}} : q_full[IDX_W-1:0];

    // SOF restarts the statistics from this sample, discarding any unterminated frame
    assign nxt_min = in_tuser ? in_tdata : ((in_tdata < run_min) ? in_tdata : run_min);
    assign nxt_max = in_tuser ? in_tdata : ((in_tdata > run_max) ? in_tdata : run_max);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            min_l      <= '0;
            scale_l    <= DATA_W'(1 << SHIFT);
            run_min    <= '1;
            run_max    <= '0;
            stat_min   <= '0;
            stat_max   <= '0;
            stat_valid <= 1'b0;
            s1_vld     <= 1'b0;
            s1_d       <= '0;
            s1_scale   <= '0;
            s1_user    <= 1'b0;
            s1_last    <= 1'b0;
            s2_vld     <= 1'b0;
            s2_p       <= '0;
            s2_user    <= 1'b0;
            s2_last    <= 1'b0;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tuser  <= 1'b0;
            out_tlast  <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            if (accept) begin
                if (in_tuser) begin
                    min_l   <= cfg_min;
                    scale_l <= cfg_scale;
                end
                run_min <= nxt_min;
                run_max <= nxt_max;
                if (in_tlast) begin
                    stat_min   <= nxt_min;
                    stat_max   <= nxt_max;
                    stat_valid <= 1'b1;
                end
            end
            if (en) begin
                s1_vld     <= in_tvalid;
                s1_d       <= diff;
                s1_scale   <= sel_scale;
                s1_user    <= in_tuser;
                s1_last    <= in_tlast;
                s2_vld     <= s1_vld;
                s2_p       <= prod;
                s2_user    <= s1_user;
                s2_last    <= s1_last;
                out_tvalid <= s2_vld;
                out_tdata  <= idx;
                out_tuser  <= s2_user;
                out_tlast  <= s2_last;
            end
        end
    end

endmodule

// File: tb/tb_color_mapping_norm_pipe.sv
module tb_color_mapping_norm_pipe;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic [17:0] cfg_min = '0;
    logic [17:0] cfg_scale = 18'h10000;
    logic [17:0] in_tdata = '0;
    logic        in_tuser = 1'b0;
    logic        in_tlast = 1'b0;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic [7:0]  out_tdata;
    logic        out_tuser;
    logic        out_tlast;
    logic        out_tvalid;
    logic        out_tready;
    logic [17:0] stat_min;
    logic [17:0] stat_max;
    logic        stat_valid;

    color_mapping_norm_pipe #(.DATA_W(18), .SHIFT(16), .IDX_W(8)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .cfg_min(cfg_min), .cfg_scale(cfg_scale),
        .in_tdata(in_tdata), .in_tuser(in_tuser), .in_tlast(in_tlast),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tuser(out_tuser), .out_tlast(out_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .stat_min(stat_min), .stat_max(stat_max), .stat_valid(stat_valid)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int d;
        bit u;
        bit l;
        int cyc;
    } beat_t;

    int    checks = 0;
    int    failures = 0;
    beat_t expq[$];
    beat_t got[$];
    int    acc_cyc[$];
    int    expd[$];
    int    cyc = 0;
    int    sv_count = 0;
    int    sv_cyc = 0;
    int    stall_cycles = 0;
    bit    mon_en = 1'b0;
    bit    rand_rdy = 1'b0;
    bit    fixed_rdy = 1'b1;

    // Reference state: coefficients, running/last-frame stats
    int    m_min = 0;
    longint m_scale = 65536;
    int    r_min = 'h3FFFF;
    int    r_max = 0;
    int    e_smin = 0;
    int    e_smax = 0;
    bit    e_sv = 1'b0;

    bit    prev_stall = 1'b0;
    int    prev_d = 0;
    bit    prev_u = 1'b0;
    bit    prev_l = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int ref_idx(input int x, input int mn, input longint sc);
        longint d;
        longint q;
        d = (x > mn) ? longint'(x - mn) : 64'sd0;
        q = (d * sc) >>> 16;
        return (q > 255) ? 255 : int'(q);
    endfunction

    // Compare process: runs every cycle, away from the active edge
    always @(negedge ap_clk) begin
        if (mon_en) begin
            beat_t e;
            beat_t g;
            cyc++;
            chk("in_tready", 64'(in_tready), 64'(!out_tvalid || out_tready));
            chk("stat_valid", 64'(stat_valid), 64'(e_sv));
            chk("stat_min", 64'(stat_min), 64'(e_smin));
            chk("stat_max", 64'(stat_max), 64'(e_smax));
            if (stat_valid) begin
                sv_count++;
                sv_cyc = cyc;
            end
            if (!in_tready) stall_cycles++;
            if (prev_stall) begin
                chk("hold_valid", 64'(out_tvalid), 64'd1);
                chk("hold_data", 64'(out_tdata), 64'(prev_d));
                chk("hold_user", 64'(out_tuser), 64'(prev_u));
                chk("hold_last", 64'(out_tlast), 64'(prev_l));
            end
            if (ap_rst) begin
                expq.delete();
                prev_stall = 1'b0;
                e_sv = 1'b0;
                e_smin = 0;
                e_smax = 0;
                m_min = 0;
                m_scale = 65536;
                r_min = 'h3FFFF;
                r_max = 0;
            end else begin
                e_sv = 1'b0;
                if (out_tvalid && out_tready) begin
                    g.d = int'(out_tdata);
                    g.u = out_tuser;
                    g.l = out_tlast;
                    g.cyc = cyc;
                    got.push_back(g);
                    if (expq.size() == 0) begin
                        chk("unexpected_out_beat", 64'd1, 64'd0);
                    end else begin
                        e = expq.pop_front();
                        chk("out_tdata", 64'(out_tdata), 64'(e.d));
                        chk("out_tuser", 64'(out_tuser), 64'(e.u));
                        chk("out_tlast", 64'(out_tlast), 64'(e.l));
                    end
                end
                prev_stall = out_tvalid && !out_tready;
                prev_d = int'(out_tdata);
                prev_u = out_tuser;
                prev_l = out_tlast;
                if (in_tvalid && in_tready) begin
                    int x;
                    x = int'(in_tdata);
                    if (in_tuser) begin
                        m_min = int'(cfg_min);
                        m_scale = longint'(cfg_scale);
                        r_min = x;
                        r_max = x;
                    end else begin
                        if (x < r_min) r_min = x;
                        if (x > r_max) r_max = x;
                    end
                    e.d = ref_idx(x, m_min, m_scale);
                    e.u = in_tuser;
                    e.l = in_tlast;
                    e.cyc = cyc;
                    expq.push_back(e);
                    acc_cyc.push_back(cyc);
                    if (in_tlast) begin
                        e_sv = 1'b1;
                        e_smin = r_min;
                        e_smax = r_max;
                    end
                end
            end
        end
    end

    // Downstream ready: fixed or random
    initial begin
        out_tready = 1'b1;
        forever begin
            @(posedge ap_clk);
            #1;
            out_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
        end
    end

    task automatic send(input int x, input bit u, input bit l);
        int n;
        n = 0;
        in_tdata = 18'(x);
        in_tuser = u;
        in_tlast = l;
        in_tvalid = 1'b1;
        @(negedge ap_clk);
        while (!in_tready && n < 200) begin
            n++;
            @(negedge ap_clk);
        end
        if (n >= 200) chk("send_timeout", 64'd1, 64'd0);
        @(posedge ap_clk);
        #1;
        in_tvalid = 1'b0;
        in_tuser = 1'b0;
        in_tlast = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 300) begin
            n++;
            @(posedge ap_clk);
            #1;
        end
        if (expq.size() != 0) chk("drain_timeout", 64'(expq.size()), 64'd0);
        repeat (3) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic check_seq(input string name);
        chk({name, "_count"}, 64'(got.size()), 64'(expd.size()));
        for (int i = 0; i < expd.size(); i++)
            chk(name, 64'((i < got.size()) ? got[i].d : -1), 64'(expd[i]));
    endtask

    task automatic clear_logs();
        got.delete();
        acc_cyc.delete();
        sv_count = 0;
        stall_cycles = 0;
    endtask

    task automatic frame1();
        cfg_min = 18'd100;
        cfg_scale = 18'h10000;
        send(150, 1, 0);
        send(100, 0, 0);
        send(50, 0, 0);
        send(1000, 0, 1);
        drain();
    endtask

    initial begin
        repeat (3) @(posedge ap_clk);
        #1;
        mon_en = 1'b1;
        chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("rst_out_tdata", 64'(out_tdata), 64'd0);
        chk("rst_stat_valid", 64'(stat_valid), 64'd0);
        chk("rst_stat_min", 64'(stat_min), 64'd0);
        chk("rst_stat_max", 64'(stat_max), 64'd0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;

        // Basic frame, latency and sideband
        clear_logs();
        frame1();
        expd = '{50, 0, 0, 255};
        check_seq("t1_data");
        chk("t1_sof_on_first", 64'((got.size() > 0) ? got[0].u : 1'b0), 64'd1);
        chk("t1_sof_only_first", 64'((got.size() > 1) ? got[1].u : 1'b1), 64'd0);
        chk("t1_eof_on_last", 64'((got.size() > 3) ? got[3].l : 1'b0), 64'd1);
        chk("t1_latency", 64'((got.size() > 0 && acc_cyc.size() > 0) ? got[0].cyc - acc_cyc[0] : -1), 64'd3);
        chk("t1_stat_min", 64'(stat_min), 64'd50);
        chk("t1_stat_max", 64'(stat_max), 64'd1000);

        // Fractional gain and saturation
        clear_logs();
        cfg_min = 18'd0;
        cfg_scale = 18'h08000;
        send(511, 1, 0);
        send(200, 0, 1);
        cfg_scale = 18'h3FFFF;
        send('h3FFFF, 1, 1);
        drain();
        expd = '{255, 100, 255};
        check_seq("t2_data");
        chk("t2_single_min", 64'(stat_min), 64'h3FFFF);
        chk("t2_single_max", 64'(stat_max), 64'h3FFFF);

        // Backpressure while a frame streams in
        clear_logs();
        fork
            frame1();
            begin
                fixed_rdy = 1'b0;
                repeat (5) @(posedge ap_clk);
                fixed_rdy = 1'b1;
            end
        join
        expd = '{50, 0, 0, 255};
        check_seq("t3_data");
        chk("t3_in_tready_dropped", 64'(stall_cycles > 0), 64'd1);

        // Frame statistics
        clear_logs();
        cfg_min = 18'd0;
        cfg_scale = 18'h10000;
        send(7, 1, 0);
        send(3, 0, 0);
        send(9, 0, 1);
        drain();
        chk("t4_pulses", 64'(sv_count), 64'd1);
        chk("t4_stat_min", 64'(stat_min), 64'd3);
        chk("t4_stat_max", 64'(stat_max), 64'd9);
        chk("t4_pulse_cycle", 64'((acc_cyc.size() == 3) ? sv_cyc - acc_cyc[2] : -1), 64'd1);

        // Mid-frame config change must not tear
        clear_logs();
        cfg_min = 18'd0;
        send(100, 1, 0);
        cfg_min = 18'd50;
        send(100, 0, 0);
        send(100, 0, 1);
        send(120, 1, 0);
        send(30, 0, 1);
        drain();
        expd = '{100, 100, 100, 70, 0};
        check_seq("t5_data");

        // Reset with beats in flight
        clear_logs();
        cfg_min = 18'd100;
        send(150, 1, 0);
        send(100, 0, 0);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        chk("t6_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("t6_stat_valid", 64'(stat_valid), 64'd0);
        repeat (4) begin
            @(posedge ap_clk);
            #1;
        end
        chk("t6_nothing_out", 64'(got.size()), 64'd0);
        chk("t6_no_pulse", 64'(sv_count), 64'd0);
        // Beat before any SOF uses the reset coefficients (floor 0, gain 1.0)
        send(200, 0, 1);
        drain();
        frame1();
        expd = '{200, 50, 0, 0, 255};
        check_seq("t6_after_reset");

        // Randomized traffic with random downstream stalls and occasional resets
        rand_rdy = 1'b1;
        for (int f = 0; f < 70; f++) begin
            int len;
            bit sof;
            bit eof;
            len = $urandom_range(1, 7);
            sof = ($urandom_range(0, 9) != 0);
            eof = ($urandom_range(0, 9) != 0);
            cfg_min = 18'($urandom_range(0, 700));
            cfg_scale = ($urandom_range(0, 3) == 0) ? 18'($urandom_range(0, 'h3FFFF)) : 18'($urandom_range(0, 'h20000));
            for (int b = 0; b < len; b++) begin
                int x;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge ap_clk);
                    #1;
                end
                x = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 'h3FFFF) : $urandom_range(0, 1200);
                send(x, sof && b == 0, eof && b == len - 1);
                if ($urandom_range(0, 60) == 0) begin
                    ap_rst = 1'b1;
                    @(posedge ap_clk);
                    #1;
                    ap_rst = 1'b0;
                end
            end
        end
        rand_rdy = 1'b0;
        fixed_rdy = 1'b1;
        drain();
        chk("final_queue_empty", 64'(expq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
